// File: rtl/frame_buffer_ctrl.sv
// Multi-buffer frame memory controller: packs pixels into words, writes them to
// a single-port frame memory and streams completed frames back out as pixels.
module frame_buffer_ctrl #(
  parameter int PIX_WIDTH    = 24,
  parameter int PIX_PER_WORD = 4,
  parameter int DATA_WIDTH   = PIX_WIDTH*PIX_PER_WORD,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int NUM_BUF      = 2,
  parameter int ADDR_WIDTH   =
    $clog2(NUM_BUF*H_ACTIVE*V_ACTIVE/PIX_PER_WORD)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  WR_VSYNC,
  input  logic                  WR_VALID,
  input  logic [PIX_WIDTH-1:0]  WR_PIX,
  input  logic                  RD_START,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [PIX_WIDTH-1:0]  RD_PIX,
  output logic                  RD_LAST,
  output logic                  RD_BUSY,
  output logic                  FRAME_DONE,
  output logic                  FRAME_DROP,
  output logic                  MEM_CSN,
  output logic                  MEM_WEN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

  localparam int WPF = H_ACTIVE*V_ACTIVE/PIX_PER_WORD;
  localparam int BW  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int WCW = $clog2(WPF+1);
  localparam int PCW = $clog2(PIX_PER_WORD);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  // write side
  logic                  r_wr_act;
  logic [BW-1:0]         r_wr_buf;
  logic [PCW-1:0]        r_pcnt;
  logic [WCW-1:0]        r_wcnt;
  logic [DATA_WIDTH-1:0] r_pack;
  logic                  r_fin;
  logic [BW-1:0]         r_fin_buf;
  logic                  r_last_valid;
  logic [BW-1:0]         r_last_done;
  logic                  r_frame_done;
  logic                  r_frame_drop;

  // memory port
  logic                  r_mem_csn;
  logic                  r_mem_wen;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;

  // read side
  logic [0:0]            r_state;
  logic [BW-1:0]         r_rd_buf;
  logic [WCW-1:0]        r_rd_wcnt;
  logic                  r_rd_acc;
  logic                  r_rd_dv;
  logic [DATA_WIDTH-1:0] r_fifo [0:1];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_ow;
  logic                  r_ov;
  logic [PCW-1:0]        r_sel;
  logic                  r_olast;
  logic [WCW-1:0]        r_pop_cnt;

  logic                  w_lv;
  logic [BW-1:0]         w_ld;
  logic                  w_tgt_ok;
  logic [BW-1:0]         w_tgt;
  logic                  w_take;
  logic [PCW-1:0]        w_pidx;
  logic [WCW-1:0]        w_wcnt;
  logic [BW-1:0]         w_buf;
  logic                  w_full;
  logic                  w_last_word;
  logic [DATA_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_busy;
  logic [2:0]            w_occ;
  logic                  w_rd_issue;
  logic                  w_acc;
  logic                  w_sel_end;
  logic                  w_pop;

  // A frame whose last word is on the bus right now already counts as done
  assign w_lv = r_last_valid | r_fin;
  assign w_ld = r_fin ? r_fin_buf : r_last_done;
  assign w_rd_busy = (r_state == S_FETCH);

  always_comb begin
    int base;
    int c;
    w_tgt_ok = 1'b0;
    w_tgt    = '0;
    c        = 0;
    base     = w_lv ? int'(w_ld) + 1 : 0;
    for (int i = 0; i < NUM_BUF; i++) begin
      c = (base + i) % NUM_BUF;
      if (!w_tgt_ok &&
          !(w_lv && c == int'(w_ld)) &&
          !(w_rd_busy && c == int'(r_rd_buf))) begin
        w_tgt_ok = 1'b1;
        w_tgt    = BW'(c);
      end
    end
  end

  assign w_take = WR_VALID & (WR_VSYNC ? w_tgt_ok : r_wr_act);
  assign w_pidx = WR_VSYNC ? '0 : r_pcnt;
  assign w_wcnt = WR_VSYNC ? '0 : r_wcnt;
  assign w_buf  = WR_VSYNC ? w_tgt : r_wr_buf;
  assign w_full = w_take & (w_pidx == PCW'(PIX_PER_WORD-1));
  assign w_last_word = w_full & (w_wcnt == WCW'(WPF-1));
  assign w_wr_addr =
    ADDR_WIDTH'(int'(w_buf)*WPF + int'(w_wcnt));

  always_comb begin
    w_word = r_pack;
    w_word[(PIX_PER_WORD-1)*PIX_WIDTH +: PIX_WIDTH] = WR_PIX;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_act     <= 1'b0;
      r_wr_buf     <= '0;
      r_pcnt       <= '0;
      r_wcnt       <= '0;
      r_pack       <= '0;
      r_fin        <= 1'b0;
      r_fin_buf    <= '0;
      r_last_valid <= 1'b0;
      r_last_done  <= '0;
      r_frame_done <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_done <= r_fin;
      r_frame_drop <= 1'b0;
      r_fin        <= 1'b0;
      if (r_fin) begin
        r_last_done  <= r_fin_buf;
        r_last_valid <= 1'b1;
      end
      if (WR_VSYNC) begin
        r_wr_act     <= w_tgt_ok;
        r_wr_buf     <= w_tgt;
        r_frame_drop <= !w_tgt_ok;
        r_pcnt       <= '0;
        r_wcnt       <= '0;
      end
      if (w_take) begin
        r_pack[int'(w_pidx)*PIX_WIDTH +: PIX_WIDTH] <= WR_PIX;
        r_pcnt <= w_full ? '0 : w_pidx + PCW'(1);
      end
      if (w_full) begin
        r_wcnt <= w_wcnt + WCW'(1);
      end
      if (w_last_word) begin
        r_wr_act  <= 1'b0;
        r_fin     <= 1'b1;
        r_fin_buf <= w_buf;
      end
    end
  end

  assign w_rd_addr =
    ADDR_WIDTH'(int'(r_rd_buf)*WPF + int'(r_rd_wcnt));
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_rd_acc}
               + {2'b00, r_rd_dv};
  assign w_rd_issue = w_rd_busy & !w_full
                    & (r_rd_wcnt != WCW'(WPF))
                    & (w_occ < 3'd2);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_mem_csn  <= 1'b1;
      r_mem_wen  <= 1'b1;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_mem_csn <= 1'b1;
      r_mem_wen <= 1'b1;
      if (w_full) begin
        r_mem_csn  <= 1'b0;
        r_mem_wen  <= 1'b0;
        r_mem_addr <= w_wr_addr;
        r_mem_din  <= w_word;
      end else if (w_rd_issue) begin
        r_mem_csn  <= 1'b0;
        r_mem_addr <= w_rd_addr;
      end
    end
  end

  assign w_acc     = r_ov & RD_READY;
  assign w_sel_end = (r_sel == PCW'(PIX_PER_WORD-1));
  assign w_pop     = (r_cnt != 2'd0)
                   & (!r_ov | (w_acc & w_sel_end & !r_olast));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_rd_buf  <= '0;
      r_rd_wcnt <= '0;
      r_rd_acc  <= 1'b0;
      r_rd_dv   <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_ow      <= '0;
      r_ov      <= 1'b0;
      r_sel     <= '0;
      r_olast   <= 1'b0;
      r_pop_cnt <= '0;
    end else begin
      r_rd_acc <= w_rd_issue;
      r_rd_dv  <= r_rd_acc;
      if (r_state == S_IDLE && RD_START && r_last_valid) begin
        r_state   <= S_FETCH;
        r_rd_buf  <= r_last_done;
        r_rd_wcnt <= '0;
        r_pop_cnt <= '0;
      end
      if (w_rd_issue) begin
        r_rd_wcnt <= r_rd_wcnt + WCW'(1);
      end
      if (r_rd_dv) begin
        r_fifo[r_wp] <= MEM_DOUT;
        r_wp         <= ~r_wp;
      end
      if (w_acc) begin
        r_sel <= w_sel_end ? '0 : r_sel + PCW'(1);
        if (w_sel_end) begin
          r_ov <= 1'b0;
          if (r_olast) r_state <= S_IDLE;
        end
      end
      if (w_pop) begin
        r_ow      <= r_fifo[r_rp];
        r_ov      <= 1'b1;
        r_sel     <= '0;
        r_olast   <= (r_pop_cnt == WCW'(WPF-1));
        r_pop_cnt <= r_pop_cnt + WCW'(1);
        r_rp      <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, r_rd_dv} - {1'b0, w_pop};
    end
  end

  assign RD_VALID   = r_ov;
  assign RD_PIX     = r_ow[int'(r_sel)*PIX_WIDTH +: PIX_WIDTH];
  assign RD_LAST    = r_ov & r_olast & w_sel_end;
  assign RD_BUSY    = w_rd_busy;
  assign FRAME_DONE = r_frame_done;
  assign FRAME_DROP = r_frame_drop;
  assign MEM_CSN    = r_mem_csn;
  assign MEM_WEN    = r_mem_wen;
  assign MEM_ADDR   = r_mem_addr;
  assign MEM_DIN    = r_mem_din;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: 8x2 frames, 4 pixels per word,
// two buffers, behavioural single-port memory with 1-cycle read latency.
module tb_frame_buffer_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        WR_VSYNC = 1'b0;
  logic        WR_VALID = 1'b0;
  logic [7:0]  WR_PIX = '0;
  logic        RD_START = 1'b0;
  logic        RD_READY = 1'b0;
  logic        RD_VALID;
  logic [7:0]  RD_PIX;
  logic        RD_LAST;
  logic        RD_BUSY;
  logic        FRAME_DONE;
  logic        FRAME_DROP;
  logic        MEM_CSN;
  logic        MEM_WEN;
  logic [2:0]  MEM_ADDR;
  logic [31:0] MEM_DIN;
  logic [31:0] MEM_DOUT = '0;

  frame_buffer_ctrl #(
    .PIX_WIDTH(8), .PIX_PER_WORD(4), .DATA_WIDTH(32),
    .H_ACTIVE(8), .V_ACTIVE(2), .NUM_BUF(2), .ADDR_WIDTH(3)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .WR_VSYNC(WR_VSYNC), .WR_VALID(WR_VALID), .WR_PIX(WR_PIX),
    .RD_START(RD_START), .RD_VALID(RD_VALID),
    .RD_READY(RD_READY), .RD_PIX(RD_PIX), .RD_LAST(RD_LAST),
    .RD_BUSY(RD_BUSY), .FRAME_DONE(FRAME_DONE),
    .FRAME_DROP(FRAME_DROP), .MEM_CSN(MEM_CSN),
    .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
    .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:7];
  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) mem[MEM_ADDR] <= MEM_DIN;
      else MEM_DOUT <= mem[MEM_ADDR];
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_drop = 0;
  int stall_err = 0;
  int pix0_cyc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_pix = '0;
  logic       prev_last = 1'b0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  int          wq_c[$];
  logic [31:0] rq_a[$];
  logic [31:0] pq[$];
  logic        lq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_stall <= 1'b0;
    end else begin
      if (!MEM_CSN && !MEM_WEN) begin
        wq_a.push_back(32'(MEM_ADDR));
        wq_d.push_back(MEM_DIN);
        wq_c.push_back(cyc);
      end
      if (!MEM_CSN && MEM_WEN) rq_a.push_back(32'(MEM_ADDR));
      if (RD_VALID && RD_READY) begin
        pq.push_back(32'(RD_PIX));
        lq.push_back(RD_LAST);
      end
      if (FRAME_DONE) n_done <= n_done + 1;
      if (FRAME_DROP) n_drop <= n_drop + 1;
      if (prev_stall && !(RD_VALID && RD_PIX == prev_pix
                          && RD_LAST == prev_last))
        stall_err <= stall_err + 1;
      prev_stall <= RD_VALID & !RD_READY;
      prev_pix   <= RD_PIX;
      prev_last  <= RD_LAST;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rd_valid"}, 32'(RD_VALID), 0);
    chk({p, "_rd_busy"}, 32'(RD_BUSY), 0);
    chk({p, "_rd_last"}, 32'(RD_LAST), 0);
    chk({p, "_rd_pix"}, 32'(RD_PIX), 0);
    chk({p, "_done"}, 32'(FRAME_DONE), 0);
    chk({p, "_drop"}, 32'(FRAME_DROP), 0);
    chk({p, "_csn"}, 32'(MEM_CSN), 1);
    chk({p, "_wen"}, 32'(MEM_WEN), 1);
    chk({p, "_addr"}, 32'(MEM_ADDR), 0);
    chk({p, "_din"}, MEM_DIN, 0);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit same,
                            input int n);
    WR_VSYNC = 1'b1;
    if (!same) begin
      tick();
      WR_VSYNC = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      WR_VALID = 1'b1;
      WR_PIX   = base + 8'(i);
      if (i == 0) pix0_cyc = cyc;
      tick();
      WR_VSYNC = 1'b0;
    end
    WR_VALID = 1'b0;
    WR_VSYNC = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_rd(input bit rnd);
    int k;
    k = 0;
    while (RD_BUSY && k < 400) begin
      if (rnd) RD_READY = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    RD_READY = 1'b1;
    chk("rd_timeout", 32'(RD_BUSY), 0);
  endtask

  task automatic chk_pixels(input string p, input logic [7:0] base);
    logic [7:0] e;
    chk({p, "_npix"}, 32'(pq.size()), 16);
    for (int i = 0; i < 16; i++) begin
      e = base + 8'(i);
      chk($sformatf("%s_pix%0d", p, i), pq[i], 32'(e));
      chk($sformatf("%s_last%0d", p, i), 32'(lq[i]),
          (i == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic start_read(input bit rdy);
    pq.delete();
    lq.delete();
    rq_a.delete();
    RD_READY = rdy;
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
  endtask

  initial begin
    int d0;
    tick();
    tick();
    chk_reset("rst");
    RSTN = 1'b1;
    tick();

    // 1: first frame lands in buffer 0
    send_frame(8'h00, 1'b0, 16);
    chk("t1_nwr", 32'(wq_a.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), wq_a[i], 32'(i));
    chk("t1_word0", wq_d[0], 32'h03020100);
    chk("t1_word1", wq_d[1], 32'h07060504);
    chk("t1_word3", wq_d[3], 32'h0F0E0D0C);
    chk("t1_done", 32'(n_done), 1);
    chk("t1_drop", 32'(n_drop), 0);

    // 2: full-rate read of buffer 0
    start_read(1'b1);
    chk("t2_busy", 32'(RD_BUSY), 1);
    chk("t2_early", 32'(RD_VALID), 0);
    wait_rd(1'b0);
    chk_pixels("t2", 8'h00);
    chk("t2_nrd", 32'(rq_a.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_raddr%0d", i), rq_a[i], 32'(i));

    // 3: same read with random backpressure
    start_read(1'b0);
    wait_rd(1'b1);
    chk_pixels("t3", 8'h00);
    chk("t3_nrd", 32'(rq_a.size()), 4);
    chk("t3_stall", 32'(stall_err), 0);

    // 4: read buffer 0 while a frame streams into buffer 1
    start_read(1'b1);
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    send_frame(8'h10, 1'b1, 16);
    wait_rd(1'b0);
    chk("t4_nwr", 32'(wq_a.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_addr%0d", i), wq_a[i], 32'(4 + i));
      chk($sformatf("t4_wcyc%0d", i), 32'(wq_c[i]),
          32'(pix0_cyc + 4 + 4*i));
    end
    chk("t4_word0", wq_d[0], 32'h13121110);
    chk("t4_word3", wq_d[3], 32'h1F1E1D1C);
    chk("t4_done", 32'(n_done), 2);
    chk_pixels("t4", 8'h00);
    chk("t4_nrd", 32'(rq_a.size()), 4);

    // 5: buffers 0 and 1 filled, reader parks on 1, then no free buffer
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    send_frame(8'h20, 1'b0, 16);
    send_frame(8'h30, 1'b0, 16);
    chk("t5_addrA", wq_a[0], 0);
    chk("t5_addrB", wq_a[4], 4);
    chk("t5_done2", 32'(n_done), 4);
    start_read(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_busy", 32'(RD_BUSY), 1);
    chk("t5_valid", 32'(RD_VALID), 1);
    chk("t5_hold", 32'(RD_PIX), 32'h30);
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    send_frame(8'h40, 1'b0, 16);
    chk("t5_addrC", wq_a[0], 0);
    chk("t5_wordC", wq_d[0], 32'h43424140);
    chk("t5_done3", 32'(n_done), 5);
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    send_frame(8'h60, 1'b1, 16);
    chk("t5_drop", 32'(n_drop), 1);
    chk("t5_nowr", 32'(wq_a.size()), 0);
    chk("t5_done4", 32'(n_done), 5);
    chk("t5_hold2", 32'(RD_PIX), 32'h30);

    // 6: asynchronous reset in the middle of a read
    RSTN = 1'b0;
    #1;
    chk_reset("t6");
    tick();
    RSTN = 1'b1;
    tick();
    start_read(1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_busy", 32'(RD_BUSY), 0);
    chk("t6_valid", 32'(RD_VALID), 0);
    chk("t6_nrd", 32'(rq_a.size()), 0);

    // aborted frame, then a full frame with extra trailing pixels
    d0 = n_done;
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    send_frame(8'h70, 1'b0, 6);
    send_frame(8'h50, 1'b1, 20);
    chk("t7_nwr", 32'(wq_a.size()), 5);
    chk("t7_abort_w", wq_d[0], 32'h73727170);
    chk("t7_addr1", wq_a[1], 0);
    chk("t7_word1", wq_d[1], 32'h53525150);
    chk("t7_addr4", wq_a[4], 3);
    chk("t7_word4", wq_d[4], 32'h5F5E5D5C);
    chk("t7_done", 32'(n_done - d0), 1);
    start_read(1'b1);
    wait_rd(1'b0);
    chk_pixels("t7", 8'h50);
    chk("t7_stall", 32'(stall_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
